sdram_responder: RTL and testbench

Synthesizable memory-side responder for the memory_control read/write port. It answers read strobes with CAS-latency-delayed data and absorbs write strobes with a fixed busy period. Storage is an on-chip word array. It replaces the behavioural SDRAM model in system-level benches and can back small FPGA builds of the KNN system.

---
 rtl/sdram_resp_pkg.sv | 26 ++
 rtl/sdram_resp_ram.sv | 21 ++
 rtl/sdram_responder.sv | 146 ++++++++++++++
 tb/tb_sdram_responder.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_resp_pkg.sv
// rtl/sdram_resp_pkg.sv - shared constants and helpers for the SDRAM responder
package sdram_resp_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WR_BUSY = 2'd2;

  // Default latencies
  localparam int CAS_LAT_DEF = 2;
  localparam int WR_CYC_DEF  = 8;

  // Width of the counter that times both the CAS wait and the write busy period
  localparam int CNT_W = 4;

  // Smallest r with 2**r >= value; exact log2 for the power-of-two data widths used here
  function automatic int log2_int(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sdram_resp_ram.sv
// rtl/sdram_resp_ram.sv - single-port synchronous word array, no reset
module sdram_resp_ram #(
  parameter int W       = 16,
  parameter int DEPTH_W = 10
) (
  input  logic               clk,
  input  logic               we,
  input  logic [DEPTH_W-1:0] addr,
  input  logic [W-1:0]       din,
  output logic [W-1:0]       dout
);

  logic [W-1:0] mem [0:(1<<DEPTH_W)-1];

  // Write on we, registered read of the addressed word every cycle (old data on a write)
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/sdram_responder.sv
// rtl/sdram_responder.sv - memory-side responder with CAS-delayed reads and fixed write busy time; optional SDRAM_RESP_RANGE_CHECK_EN
module sdram_responder
  import sdram_resp_pkg::*;
#(
  parameter int W       = 16,
  parameter int ADDR_W  = 25,
  parameter int DEPTH_W = 10,
  parameter int CAS_LAT = CAS_LAT_DEF,
  parameter int WR_CYC  = WR_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic [ADDR_W-1:0] readaddress,
  input  logic              write,
  input  logic [ADDR_W-1:0] writeaddress,
  input  logic [W-1:0]      writedata,
  output logic [W-1:0]      readdata,
  output logic              rd_valid,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  // Addresses are bit addresses: drop the bits that select a bit inside a word
  localparam int LW    = log2_int(W);
  localparam int IDX_W = ADDR_W - LW;

  localparam logic [CNT_W-1:0] CAS_INIT = CNT_W'(CAS_LAT - 1);
  localparam logic [CNT_W-1:0] WR_INIT  = CNT_W'(WR_CYC - 1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [DEPTH_W-1:0] rd_word;
  logic               rd_oor;

  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   wr_idx;
  logic               rd_oor_now;
  logic               wr_oor_now;
  logic               unused_addr;

  logic               ram_we;
  logic [DEPTH_W-1:0] ram_addr;
  logic [W-1:0]       ram_din;
  logic [W-1:0]       ram_dout;

  assign rd_idx = readaddress[ADDR_W-1:LW];
  assign wr_idx = writeaddress[ADDR_W-1:LW];

`ifdef SDRAM_RESP_RANGE_CHECK_EN
  // Any set bit above the array index makes the access out of range
  assign rd_oor_now  = (rd_idx >> DEPTH_W) != '0;
  assign wr_oor_now  = (wr_idx >> DEPTH_W) != '0;
  assign unused_addr = ^{readaddress[LW-1:0], writeaddress[LW-1:0]};
`else
  // Upper index bits are dropped, so the array simply wraps
  assign rd_oor_now  = 1'b0;
  assign wr_oor_now  = 1'b0;
  assign unused_addr = ^{readaddress[LW-1:0], writeaddress[LW-1:0],
                         rd_idx[IDX_W-1:DEPTH_W], wr_idx[IDX_W-1:DEPTH_W]};
`endif

  assign busy = (state != IDLE);

  // RAM port steering: in IDLE address the incoming request so the accept edge
  // both commits a write and preloads dout for a read; while waiting, hold the
  // latched read word so dout stays stable until the CAS wait expires
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = rd_word;
    ram_din  = writedata;
    if (state == IDLE) begin
      if (read) begin
        ram_addr = rd_idx[DEPTH_W-1:0];
      end else if (write) begin
        ram_addr = wr_idx[DEPTH_W-1:0];
        ram_we   = !wr_oor_now;
      end
    end
  end

  sdram_resp_ram #(
    .W       (W),
    .DEPTH_W (DEPTH_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  // Request FSM: accept in IDLE (read wins), count down the CAS wait or write busy period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rd_word  <= '0;
      rd_oor   <= 1'b0;
      readdata <= '0;
      rd_valid <= 1'b0;
      ack      <= 1'b0;
      err      <= 1'b0;
    end else begin
      ack      <= 1'b0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (read) begin
            ack     <= 1'b1;
            rd_word <= rd_idx[DEPTH_W-1:0];
            rd_oor  <= rd_oor_now;
            cnt     <= CAS_INIT;
            state   <= RD_WAIT;
          end else if (write) begin
            ack     <= 1'b1;
            err     <= wr_oor_now;
            cnt     <= WR_INIT;
            state   <= WR_BUSY;
          end
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            readdata <= rd_oor ? '0 : ram_dout;
            rd_valid <= 1'b1;
            err      <= rd_oor;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_BUSY: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// tb/tb_sdram_responder.sv - self-checking bench for sdram_responder
`timescale 1ns/1ps
module tb_sdram_responder;

  localparam int W       = 16;
  localparam int ADDR_W  = 25;
  localparam int DEPTH_W = 10;
  localparam int CAS     = 2;
  localparam int WRC     = 8;
  localparam int NWORDS  = 1 << DEPTH_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              read = 1'b0;
  logic              write = 1'b0;
  logic [ADDR_W-1:0] readaddress = '0;
  logic [ADDR_W-1:0] writeaddress = '0;
  logic [W-1:0]      writedata = '0;

  logic [W-1:0] readdata, readdata1, readdata4;
  logic rd_valid, ack, busy, err;
  logic rd_valid1, ack1, busy1, err1;
  logic rd_valid4, ack4, busy4, err4;

  int total = 0;
  int bad = 0;

  // Reference memory: what each word should hold, and whether it was ever written
  logic [W-1:0] mdl [0:NWORDS-1];
  bit           mdl_ok [0:NWORDS-1];

  always #5 clk = ~clk;

  sdram_responder #(.W(W), .ADDR_W(ADDR_W), .DEPTH_W(DEPTH_W)) dut (
    .clk(clk), .rst(rst), .read(read), .readaddress(readaddress),
    .write(write), .writeaddress(writeaddress), .writedata(writedata),
    .readdata(readdata), .rd_valid(rd_valid), .ack(ack), .busy(busy), .err(err));

  sdram_responder #(.W(W), .ADDR_W(ADDR_W), .DEPTH_W(DEPTH_W), .CAS_LAT(1)) dut_c1 (
    .clk(clk), .rst(rst), .read(read), .readaddress(readaddress),
    .write(write), .writeaddress(writeaddress), .writedata(writedata),
    .readdata(readdata1), .rd_valid(rd_valid1), .ack(ack1), .busy(busy1), .err(err1));

  sdram_responder #(.W(W), .ADDR_W(ADDR_W), .DEPTH_W(DEPTH_W), .CAS_LAT(4)) dut_c4 (
    .clk(clk), .rst(rst), .read(read), .readaddress(readaddress),
    .write(write), .writeaddress(writeaddress), .writedata(writedata),
    .readdata(readdata4), .rd_valid(rd_valid4), .ack(ack4), .busy(busy4), .err(err4));

  function automatic bit model_oor(input logic [ADDR_W-1:0] a);
`ifdef SDRAM_RESP_RANGE_CHECK_EN
    return (a / W) >= NWORDS;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_word(input logic [ADDR_W-1:0] a);
    return int'((a / W) % NWORDS);
  endfunction

  function automatic logic [W-1:0] model_read(input logic [ADDR_W-1:0] a);
    if (model_oor(a)) return '0;
    return mdl[model_word(a)];
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_ack(output int n, output logic e, output bit to);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack !== 1'b1 && n < 60);
    to = (ack !== 1'b1);
    e  = err;
  endtask

  task automatic wr_txn(input logic [ADDR_W-1:0] a, input logic [W-1:0] d,
                        output int lat, output logic e, output bit to);
    @(negedge clk);
    write = 1'b1; writeaddress = a; writedata = d;
    wait_ack(lat, e, to);
    write = 1'b0;
    if (!model_oor(a)) begin
      mdl[model_word(a)]    = d;
      mdl_ok[model_word(a)] = 1'b1;
    end
  endtask

  task automatic rd_txn(input logic [ADDR_W-1:0] a, output int lat, output int off,
                        output logic [W-1:0] data, output logic e, output bit to);
    logic e0;
    @(negedge clk);
    read = 1'b1; readaddress = a;
    wait_ack(lat, e0, to);
    read = 1'b0;
    off = 0;
    do begin
      @(negedge clk);
      off++;
    end while (rd_valid !== 1'b1 && off < 20);
    if (rd_valid !== 1'b1) to = 1'b1;
    data = readdata;
    e    = err;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({readdata, rd_valid, ack, busy, err} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", {readdata, rd_valid, ack, busy, err});
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_basic();
    int lat, off; logic e; bit to; logic [W-1:0] d;
    wr_txn(25'h30, 16'h1234, lat, e, to);
    total++;
    if (to || lat !== 1) begin bad++; $display("FAIL basic_wr_ack: lat=%0d to=%0d want lat 1", lat, to); end
    total++;
    if (e !== 1'b0) begin bad++; $display("FAIL basic_wr_err: got %b want 0", e); end
    wait_idle();
    rd_txn(25'h30, lat, off, d, e, to);
    total++;
    if (to || lat !== 1 || off !== CAS) begin
      bad++; $display("FAIL basic_rd_timing: lat=%0d off=%0d to=%0d want 1 %0d", lat, off, to, CAS);
    end
    total++;
    if (d !== model_read(25'h30)) begin bad++; $display("FAIL basic_rd_data: got %h want %h", d, model_read(25'h30)); end
  endtask

  task automatic test_write_busy();
    int n, k, bc, off; logic e; bit to;
    wait_idle();
    @(negedge clk);
    write = 1'b1; writeaddress = 25'd5 * W; writedata = 16'hBEEF;
    wait_ack(n, e, to);
    write = 1'b0;
    mdl[5] = 16'hBEEF; mdl_ok[5] = 1'b1;
    total++;
    if (to || n !== 1) begin bad++; $display("FAIL wb_ack: lat=%0d to=%0d want 1", n, to); end
    bc = (busy === 1'b1) ? 1 : 0;
    @(negedge clk);
    k = 1;
    read = 1'b1; readaddress = 25'd5 * W;
    if (busy === 1'b1) bc++;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (ack === 1'b1) break;
      if (busy === 1'b1) bc++;
    end
    read = 1'b0;
    total++;
    if (bc !== WRC) begin bad++; $display("FAIL wb_busy_len: got %0d want %0d", bc, WRC); end
    total++;
    if (k !== WRC + 1) begin bad++; $display("FAIL wb_rd_ack_pos: got %0d want %0d", k, WRC + 1); end
    off = 0;
    do begin @(negedge clk); off++; end while (rd_valid !== 1'b1 && off < 20);
    total++;
    if (off !== CAS || readdata !== mdl[5]) begin
      bad++; $display("FAIL wb_rd_data: off=%0d data=%h want %0d %h", off, readdata, CAS, mdl[5]);
    end
  endtask

  task automatic test_priority();
    int n, k, off, lat; logic e; bit to; logic [W-1:0] d;
    wait_idle();
    @(negedge clk);
    read = 1'b1; readaddress = 25'h30;
    write = 1'b1; writeaddress = 25'd7 * W; writedata = 16'h0042;
    wait_ack(n, e, to);
    read = 1'b0;
    off = 0;
    do begin @(negedge clk); off++; end while (rd_valid !== 1'b1 && off < 20);
    total++;
    if (off !== CAS || readdata !== mdl[3]) begin
      bad++; $display("FAIL prio_read_first: off=%0d data=%h want %0d %h", off, readdata, CAS, mdl[3]);
    end
    k = 0;
    do begin @(negedge clk); k++; end while (ack !== 1'b1 && k < 20);
    write = 1'b0;
    mdl[7] = 16'h0042; mdl_ok[7] = 1'b1;
    total++;
    if (k !== 1) begin bad++; $display("FAIL prio_write_ack: got %0d cycles after rd_valid want 1", k); end
    wait_idle();
    rd_txn(25'd7 * W, lat, off, d, e, to);
    total++;
    if (to || d !== 16'h0042) begin bad++; $display("FAIL prio_readback: got %h want 0042", d); end
  endtask

  task automatic test_back_to_back();
    int n, k; logic e; bit to; logic [W-1:0] first;
    wait_idle();
    first = 'x;
    @(negedge clk);
    read = 1'b1; readaddress = 25'd5 * W;
    wait_ack(n, e, to);
    readaddress = 25'd7 * W;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (rd_valid === 1'b1) first = readdata;
      if (ack === 1'b1) break;
    end
    read = 1'b0;
    total++;
    if (k !== CAS + 1) begin bad++; $display("FAIL b2b_interval: got %0d want %0d", k, CAS + 1); end
    total++;
    if (first !== mdl[5]) begin bad++; $display("FAIL b2b_first: got %h want %h", first, mdl[5]); end
    k = 0;
    do begin @(negedge clk); k++; end while (rd_valid !== 1'b1 && k < 20);
    total++;
    if (readdata !== mdl[7]) begin bad++; $display("FAIL b2b_second: got %h want %h", readdata, mdl[7]); end
  endtask

  task automatic test_reset_abort();
    int n, pulses, lat, off; logic e; bit to; logic [W-1:0] d;
    wait_idle();
    @(negedge clk);
    read = 1'b1; readaddress = 25'h30;
    wait_ack(n, e, to);
    read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({readdata, rd_valid, ack, busy, err} !== '0) begin
      bad++; $display("FAIL abort_outputs: got %h want 0", {readdata, rd_valid, ack, busy, err});
    end
    pulses = 0;
    repeat (3) begin @(negedge clk); if (rd_valid === 1'b1) pulses++; end
    rst = 1'b1;
    repeat (6) begin @(negedge clk); if (rd_valid === 1'b1) pulses++; end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL abort_no_valid: got %0d pulses want 0", pulses); end
    rd_txn(25'h30, lat, off, d, e, to);
    total++;
    if (to || d !== 16'h1234) begin bad++; $display("FAIL abort_mem_kept: got %h want 1234", d); end
  endtask

  task automatic test_range();
    int lat, off; logic e; bit to; logic [W-1:0] d;
    logic [ADDR_W-1:0] far;
    far = 25'(NWORDS * W);
    wait_idle();
    wr_txn(25'h0000009, 16'h5A5A, lat, e, to);
    wait_idle();
    wr_txn(far + 25'd3, 16'h7777, lat, e, to);
    total++;
    if (e !== model_oor(far)) begin bad++; $display("FAIL range_wr_err: got %b want %b", e, model_oor(far)); end
    wait_idle();
    rd_txn(far, lat, off, d, e, to);
    total++;
    if (to || d !== model_read(far) || off !== CAS) begin
      bad++; $display("FAIL range_rd_data: got %h off=%0d want %h", d, off, model_read(far));
    end
    total++;
    if (e !== model_oor(far)) begin bad++; $display("FAIL range_rd_err: got %b want %b", e, model_oor(far)); end
    wait_idle();
    rd_txn(25'h0, lat, off, d, e, to);
    total++;
    if (to || d !== model_read(25'h0) || e !== 1'b0) begin
      bad++; $display("FAIL range_word0: got %h err=%b want %h", d, e, model_read(25'h0));
    end
  endtask

  task automatic test_unaligned();
    int lat, off; logic e; bit to; logic [W-1:0] d;
    wait_idle();
    rd_txn(25'h35, lat, off, d, e, to);
    total++;
    if (to || d !== mdl[3]) begin bad++; $display("FAIL unaligned: got %h want %h", d, mdl[3]); end
  endtask

  task automatic test_random();
    int lat, off, w; logic e; bit to; logic [W-1:0] d;
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 30; i++) begin
      w = int'($urandom_range(NWORDS - 1, 0));
      a = 25'(w * W + int'($urandom_range(W - 1, 0)));
      if (!mdl_ok[w] || ($urandom % 2) == 0) begin
        wr_txn(a, 16'($urandom), lat, e, to);
        total++;
        if (to || e !== 1'b0) begin bad++; $display("FAIL rand_wr %0d: to=%0d err=%b want 0 0", i, to, e); end
      end else begin
        rd_txn(a, lat, off, d, e, to);
        total++;
        if (to || off !== CAS || d !== model_read(a) || e !== 1'b0) begin
          bad++; $display("FAIL rand_rd %0d: word %0d got %h off=%0d err=%b want %h off=%0d", i, w, d, off, e, model_read(a), CAS);
        end
      end
    end
  endtask

  task automatic test_cas_sweep();
    int n, o1, o4, k; logic e; bit to; int lat;
    logic [W-1:0] v, d1, d4;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    v = 16'($urandom);
    wr_txn(25'd9 * W, v, lat, e, to);
    repeat (20) @(negedge clk);
    read = 1'b1; readaddress = 25'd9 * W;
    wait_ack(n, e, to);
    read = 1'b0;
    total++;
    if (to || ack1 !== 1'b1 || ack4 !== 1'b1) begin
      bad++; $display("FAIL sweep_ack: ack1=%b ack4=%b to=%0d want 1 1", ack1, ack4, to);
    end
    o1 = -1; o4 = -1; d1 = 'x; d4 = 'x;
    for (k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (rd_valid1 === 1'b1 && o1 < 0) begin o1 = k; d1 = readdata1; end
      if (rd_valid4 === 1'b1 && o4 < 0) begin o4 = k; d4 = readdata4; end
    end
    total++;
    if (o1 !== 1 || d1 !== v) begin bad++; $display("FAIL sweep_cas1: off=%0d data=%h want 1 %h", o1, d1, v); end
    total++;
    if (o4 !== 4 || d4 !== v) begin bad++; $display("FAIL sweep_cas4: off=%0d data=%h want 4 %h", o4, d4, v); end
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) begin
      mdl[i]    = '0;
      mdl_ok[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_write_busy();
    test_priority();
    test_back_to_back();
    test_reset_abort();
    test_range();
    test_unaligned();
    test_random();
    test_cas_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
